// File: rtl/pin_entry_controller.sv
// PIN entry front end: latches the card account, collects four BCD digits, samples the
// authenticator verdicts and locks after MAX_TRIES failures. Define ENTRY_TIMEOUT_EN for the COLLECT idle timeout.
module pin_entry_controller #(
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  card_acc_num,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   input  logic        key_clear,
   input  logic        key_cancel,
   input  logic        acc_found_stat,
   input  logic        acc_auth_stat,
   input  logic [3:0]  acc_index_in,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic        busy,
   output logic        done,
   output logic        granted,
   output logic [3:0]  acc_index,
   output logic        locked,
   output logic [1:0]  tries_left,
   output logic [1:0]  fail_code
);

   typedef enum logic [2:0] {StIdle, StCheck, StCollect, StVerify, StLocked} state_e;

   localparam logic [1:0] MaxTries = 2'(MAX_TRIES);

   if (MAX_TRIES < 1 || MAX_TRIES > 3 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
   begin : g_param_check
      $error("pin_entry_controller: parameter out of range");
   end

   state_e      state_q, state_d;
   logic [3:0]  acc_num_q, acc_num_d;
   logic [15:0] pin_q, pin_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        granted_q, granted_d;
   logic [3:0]  acc_index_q, acc_index_d;
   logic        locked_q, locked_d;
   logic [1:0]  tries_q, tries_d;
   logic [1:0]  fail_q, fail_d;
   logic        busy_q, busy_d;
`ifdef ENTRY_TIMEOUT_EN
   logic [15:0] tmo_q, tmo_d;
`endif

   // clear outranks a key in the same cycle
   logic key_ok;
   assign key_ok = key_valid && !key_clear && (key_digit <= 4'd9);

   always_comb begin
      state_d     = state_q;
      acc_num_d   = acc_num_q;
      pin_d       = pin_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      granted_d   = granted_q;
      acc_index_d = acc_index_q;
      locked_d    = locked_q;
      tries_d     = tries_q;
      fail_d      = fail_q;
`ifdef ENTRY_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_num_d = card_acc_num;
               pin_d     = '0;
               cnt_d     = '0;
               granted_d = 1'b0;
               fail_d    = 2'd0;
               tries_d   = MaxTries;
               state_d   = StCheck;
            end
         end
         StCheck: begin
`ifdef ENTRY_TIMEOUT_EN
            tmo_d = '0;
`endif
            if (!acc_found_stat) begin
               fail_d  = 2'd1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (key_cancel) begin
               fail_d  = 2'd3;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
`ifdef ENTRY_TIMEOUT_EN
               tmo_d = tmo_q + 16'd1;
`endif
               if (key_clear) begin
                  pin_d = '0;
                  cnt_d = '0;
               end else if (key_ok) begin
                  pin_d = {pin_q[11:0], key_digit};
                  cnt_d = cnt_q + 2'd1;
`ifdef ENTRY_TIMEOUT_EN
                  tmo_d = '0;
`endif
                  if (cnt_q == 2'd3) state_d = StVerify;
               end
`ifdef ENTRY_TIMEOUT_EN
               if (!key_ok && (tmo_q + 16'd1 == 16'(TIMEOUT_CYCLES))) begin
                  fail_d  = 2'd3;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
`endif
            end
         end
         StVerify: begin
            if (acc_auth_stat) begin
               granted_d   = 1'b1;
               acc_index_d = acc_index_in;
               fail_d      = 2'd0;
               done_d      = 1'b1;
               state_d     = StIdle;
            end else begin
               tries_d = tries_q - 2'd1;
               if (tries_q == 2'd1) begin
                  locked_d = 1'b1;
                  fail_d   = 2'd2;
                  done_d   = 1'b1;
                  state_d  = StLocked;
               end else begin
                  pin_d   = '0;
                  cnt_d   = '0;
`ifdef ENTRY_TIMEOUT_EN
                  tmo_d   = '0;
`endif
                  state_d = StCollect;
               end
            end
         end
         StLocked: ;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StCheck) || (state_d == StCollect) || (state_d == StVerify);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_num_q   <= '0;
         pin_q       <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         granted_q   <= 1'b0;
         acc_index_q <= '0;
         locked_q    <= 1'b0;
         tries_q     <= '0;
         fail_q      <= '0;
         busy_q      <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         acc_num_q   <= acc_num_d;
         pin_q       <= pin_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         granted_q   <= granted_d;
         acc_index_q <= acc_index_d;
         locked_q    <= locked_d;
         tries_q     <= tries_d;
         fail_q      <= fail_d;
         busy_q      <= busy_d;
`ifdef ENTRY_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign acc_num    = acc_num_q;
   assign pin        = pin_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign granted    = granted_q;
   assign acc_index  = acc_index_q;
   assign locked     = locked_q;
   assign tries_left = tries_q;
   assign fail_code  = fail_q;

endmodule

// File: tb/tb_pin_entry_controller.sv
// Randomized session-level bench for pin_entry_controller; expectations come from a
// digit-queue / attempt-count model of each session.
module tb_pin_entry_controller;

   localparam int unsigned MaxTries = 3;
   localparam int unsigned Tmo      = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  card_acc_num = '0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_digit = '0;
   logic        key_clear = 1'b0;
   logic        key_cancel = 1'b0;
   logic        acc_found_stat = 1'b0;
   logic        acc_auth_stat = 1'b0;
   logic [3:0]  acc_index_in = '0;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic        busy, done, granted, locked;
   logic [3:0]  acc_index;
   logic [1:0]  tries_left, fail_code;

   pin_entry_controller #(
      .MAX_TRIES      (MaxTries),
      .TIMEOUT_CYCLES (Tmo)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .card_acc_num   (card_acc_num),
      .key_valid      (key_valid),
      .key_digit      (key_digit),
      .key_clear      (key_clear),
      .key_cancel     (key_cancel),
      .acc_found_stat (acc_found_stat),
      .acc_auth_stat  (acc_auth_stat),
      .acc_index_in   (acc_index_in),
      .acc_num        (acc_num),
      .pin            (pin),
      .busy           (busy),
      .done           (done),
      .granted        (granted),
      .acc_index      (acc_index),
      .locked         (locked),
      .tries_left     (tries_left),
      .fail_code      (fail_code)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // session model
   logic [3:0] m_acc, m_idx;
   logic       m_granted, m_locked;
   int         m_tries, m_fail;
   int         digits[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pin_of();
      logic [15:0] p = '0;
      foreach (digits[i]) p = (p << 4) | 16'(digits[i]);
      return p;
   endfunction

   task automatic check_static(input string tag, input logic exp_busy);
      check_val({tag, ".busy"}, busy, exp_busy);
      check_val({tag, ".acc_num"}, acc_num, m_acc);
      check_val({tag, ".granted"}, granted, m_granted);
      check_val({tag, ".acc_index"}, acc_index, m_idx);
      check_val({tag, ".locked"}, locked, m_locked);
      check_val({tag, ".tries"}, tries_left, 32'(m_tries));
      check_val({tag, ".fail"}, fail_code, 32'(m_fail));
   endtask

   task automatic do_reset();
      start = 0; key_valid = 0; key_clear = 0; key_cancel = 0;
      rst_n = 0;
      step();
      rst_n = 1;
      m_acc = 0; m_idx = 0; m_granted = 0; m_locked = 0; m_tries = 0; m_fail = 0;
      digits.delete();
      check_static("reset", 1'b0);
      check_val("reset.pin", pin, 0);
      check_val("reset.done", done, 0);
   endtask

   task automatic start_session(input logic [3:0] acc, input bit found, output bit ok);
      start = 1; card_acc_num = acc; acc_found_stat = found;
      step();
      start = 0;
      ok = 0;
      if (m_locked) begin
         check_static("start_locked", 1'b0);
         check_val("start_locked.done", done, 0);
         return;
      end
      m_acc = acc; m_granted = 0; m_fail = 0; m_tries = MaxTries;
      digits.delete();
      check_static("start", 1'b1);
      check_val("start.done", done, 0);
      check_val("start.pin", pin, 0);
      step();
      acc_found_stat = 1'($urandom);
      if (!found) begin
         m_fail = 1;
         check_val("notfound.done", done, 1);
         check_static("notfound", 1'b0);
         step();
         check_val("notfound.done_end", done, 0);
      end else begin
         check_val("check.done", done, 0);
         check_static("collect", 1'b1);
         ok = 1;
      end
   endtask

   task automatic press(input logic [3:0] d);
      key_valid = 1; key_digit = d;
      step();
      key_valid = 0;
      if (d <= 9) digits.push_back(int'(d));
      if (digits.size() < 4) begin
         check_val("press.pin", pin, pin_of());
         check_val("press.done", done, 0);
      end
   endtask

   // idle cycle that may carry an ignored start strobe
   task automatic gap();
      if ($urandom_range(0, 1) == 1) begin
         start = 1'($urandom); card_acc_num = 4'($urandom);
         step();
         start = 0;
         check_val("gap.acc_num", acc_num, m_acc);
      end
   endtask

   task automatic clear_key();
      key_clear = 1; key_valid = 1'($urandom); key_digit = 4'($urandom_range(0, 9));
      step();
      key_clear = 0; key_valid = 0;
      digits.delete();
      check_val("clear.pin", pin, 0);
   endtask

   task automatic cancel_now();
      key_cancel = 1; key_valid = 1; key_clear = 1'($urandom);
      key_digit = 4'($urandom_range(0, 9));
      step();
      key_cancel = 0; key_valid = 0; key_clear = 0;
      m_fail = 3;
      check_val("cancel.done", done, 1);
      check_val("cancel.pin", pin, pin_of());
      check_static("cancel", 1'b0);
      step();
      check_val("cancel.done_end", done, 0);
   endtask

   // must be called right after an accepted key or COLLECT entry
   task automatic timeout_or_wait();
`ifdef ENTRY_TIMEOUT_EN
      repeat (Tmo - 1) step();
      check_val("tmo.early_done", done, 0);
      check_val("tmo.early_busy", busy, 1);
      step();
      m_fail = 3;
      check_val("tmo.done", done, 1);
      check_static("tmo", 1'b0);
      step();
      check_val("tmo.done_end", done, 0);
`else
      repeat (1000) step();
      check_val("wait.busy", busy, 1);
      check_val("wait.done", done, 0);
      check_val("wait.pin", pin, pin_of());
      cancel_now();
`endif
   endtask

   // VERIFY cycle and verdict; acc_auth_stat/acc_index_in already driven
   task automatic verdict(input bit auth, output bit over);
      check_val("verify.pin", pin, pin_of());
      check_val("verify.busy", busy, 1);
      check_val("verify.done", done, 0);
      step();
      over = 1;
      if (auth) begin
         m_granted = 1; m_idx = acc_index_in; m_fail = 0;
         check_val("grant.done", done, 1);
         check_static("grant", 1'b0);
      end else begin
         m_tries--;
         if (m_tries == 0) begin
            m_locked = 1; m_fail = 2;
            check_val("lock.done", done, 1);
            check_static("lock", 1'b0);
         end else begin
            check_val("retry.done", done, 0);
            check_static("retry", 1'b1);
            check_val("retry.pin", pin, 0);
            digits.delete();
            over = 0;
         end
      end
      acc_auth_stat = 0;
      if (over) begin
         step();
         check_val("end.done", done, 0);
         check_static("end", 1'b0);
      end
   endtask

   task automatic attempt(input bit auth, output bit over);
      int n;
      if ($urandom_range(0, 2) == 0) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) press(4'($urandom_range(0, 9)));
         gap();
         clear_key();
      end
      for (int i = 0; i < 4; i++) begin
         gap();
         if ($urandom_range(0, 3) == 0) press(4'($urandom_range(10, 15)));
         if (i == 3) begin
            acc_auth_stat = auth;
            acc_index_in = 4'($urandom);
         end
         press(4'($urandom_range(0, 9)));
      end
      verdict(auth, over);
   endtask

   initial begin
      bit ok, over;
      int r, k;
      do_reset();

      // grant path with a fixed PIN
      start_session(4'd5, 1'b1, ok);
      press(4'd1); press(4'd2); press(4'd3);
      acc_auth_stat = 1; acc_index_in = 4'd5;
      press(4'd4);
      check_val("dir.pin1234", pin, 32'h1234);
      verdict(1'b1, over);
      check_val("dir.acc_index5", acc_index, 5);

      // account not found
      start_session(4'd3, 1'b0, ok);

      // three wrong PINs -> lockout, later starts ignored
      start_session(4'd7, 1'b1, ok);
      for (int a = 0; a < 3; a++) begin
         for (int i = 0; i < 3; i++) press(4'(a + i));
         acc_auth_stat = 0;
         press(4'd0);
         verdict(1'b0, over);
      end
      check_val("dir.locked", locked, 1);
      start_session(4'd9, 1'b1, ok);
      start_session(4'd1, 1'b1, ok);
      do_reset();

      // invalid digit and clear
      start_session(4'd2, 1'b1, ok);
      press(4'd7); press(4'd12); press(4'd8);
      clear_key();
      press(4'd9); press(4'd9); press(4'd9);
      acc_auth_stat = 0;
      press(4'd9);
      check_val("dir.pin9999", pin, 32'h9999);
      verdict(1'b0, over);
      cancel_now();

      // timeout / indefinite wait
      start_session(4'd4, 1'b1, ok);
      press(4'd6);
      timeout_or_wait();

      // reset mid-entry
      start_session(4'd8, 1'b1, ok);
      press(4'd1); press(4'd2);
      do_reset();

      for (int s = 0; s < 40; s++) begin
         if (m_locked) begin
            start_session(4'($urandom), 1'b1, ok);
            do_reset();
         end
         start_session(4'($urandom), $urandom_range(0, 4) != 0, ok);
         over = !ok;
         while (!over) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 3);
            if (r == 0) begin
               for (int i = 0; i < k; i++) press(4'($urandom_range(0, 9)));
               cancel_now();
               over = 1;
            end else if (r == 1) begin
               for (int i = 0; i < k; i++) press(4'($urandom_range(0, 9)));
               timeout_or_wait();
               over = 1;
            end else if (r == 2 && (s % 5) == 0) begin
               for (int i = 0; i < k; i++) press(4'($urandom_range(0, 9)));
               do_reset();
               over = 1;
            end else begin
               attempt($urandom_range(0, 2) == 0, over);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pin_entry_controller.md
# pin_entry_controller

Sequential front end that drives the combinational account authenticator. It latches the card's account number and collects four BCD PIN digits from the keypad. It presents the assembled account/PIN pair to the authenticator, samples the found/authenticated verdicts, counts failed attempts and locks the terminal after too many failures. It sits between the keypad/card-reader logic and the authenticator, and feeds the transaction controller through `granted`, `acc_index` and `done`.

## Interface
- `MAX_TRIES`, 3, PIN attempts per session; legal range 1..3.
- `TIMEOUT_CYCLES`, 255, idle cycles allowed between accepted keys in COLLECT; legal range 1..65535.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle card-inserted strobe; honoured only in IDLE.
- `card_acc_num`  in  4  account number from the card; sampled with `start`.
- `key_valid`  in  1  one-cycle keypad strobe.
- `key_digit`  in  4  BCD key value; values 10..15 are ignored.
- `key_clear`  in  1  discard the digits entered so far.
- `key_cancel`  in  1  abort the session.
- `acc_found_stat`  in  1  authenticator verdict: account found.
- `acc_auth_stat`  in  1  authenticator verdict: PIN authenticated.
- `acc_index_in`  in  4  authenticator database index.
- `acc_num`  out  4  account number to the authenticator.
- `pin`  out  16  PIN to the authenticator; four nibbles, first digit in [15:12].
- `busy`  out  1  high in every state except IDLE and LOCKED.
- `done`  out  1  one-cycle session-end pulse.
- `granted`  out  1  session authenticated; held until the next accepted `start`.
- `acc_index`  out  4  index latched on grant.
- `locked`  out  1  sticky lockout flag.
- `tries_left`  out  2  remaining attempts.
- `fail_code`  out  2  0 none, 1 account not found, 2 PIN retries exhausted, 3 cancel or timeout.

## Operation
- **IDLE**
  - `start` latches `card_acc_num` into `acc_num`.
  - Clears `pin`, the digit count, `granted` and `fail_code`.
  - Loads `tries_left` = `MAX_TRIES`, then goes to CHECK.
- **CHECK** (one cycle)
  - Samples `acc_found_stat`.
  - If 0: `fail_code`=1, pulse `done`, go to IDLE.
  - Otherwise go to COLLECT.
- **COLLECT**
  - Per cycle the priority is `key_cancel` > `key_clear` > `key_valid`.
  - Cancel: `fail_code`=3, pulse `done`, go to IDLE.
  - Clear: `pin`=0, count=0.
  - Valid key with digit ≤9: `pin` = {`pin`[11:0], digit}, count+1, timeout counter reset.
  - On the 4th accepted digit, go to VERIFY. Further keys in the same cycle are not possible; keys in VERIFY are ignored.
  - Timeout counter reaches `TIMEOUT_CYCLES` with no accepted key: `fail_code`=3, pulse `done`, go to IDLE.
- **VERIFY** (one cycle)
  - Samples `acc_auth_stat`.
  - If 1: `granted`=1, `acc_index`=`acc_index_in`, `fail_code`=0, pulse `done`, go to IDLE.
  - If 0: `tries_left`−1.
    - Result 0: `locked`=1, `fail_code`=2, pulse `done`, go to LOCKED.
    - Otherwise clear `pin` and the count, go to COLLECT.
- **LOCKED**
  - Absorbing state; all inputs ignored.
  - Left only by `rst_n`=0.
- `start` outside IDLE is ignored.
- `pin` shows partial entry during COLLECT. The authenticator evaluates it continuously, but its verdicts are sampled only in CHECK and VERIFY.

## Timing
- All outputs are registered.
- Reset values (rst_n=0 at an edge): state IDLE, `acc_num`=0, `pin`=0, `busy`=0, `done`=0, `granted`=0, `acc_index`=0, `locked`=0, `tries_left`=0, `fail_code`=0, digit count and timeout counter 0.
- Reset mid-session aborts immediately. No `done` pulse is produced.
- `start` at edge N: `busy`=1 and CHECK in cycle N+1.
  - Not found: `done` high in cycle N+2.
  - Found: COLLECT from cycle N+2.
- 4th digit accepted at edge E: VERIFY in cycle E+1; verdict (`done`, `granted`, `tries_left`, `locked`) visible in cycle E+2.
- `done` is exactly one cycle wide and coincides with the final `fail_code`/`granted` values.
- Timeout fires at the edge on which the counter equals `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES` cycles after the last accepted key or COLLECT entry.
- `key_clear` and a valid key in the same cycle: clear wins and the key is dropped.

## Configuration
- `ENTRY_TIMEOUT_EN` defined:
  - Timeout counter present.
  - COLLECT exits with `fail_code`=3 after `TIMEOUT_CYCLES` idle cycles.
- Not defined:
  - Counter and `TIMEOUT_CYCLES` comparison are compiled out.
  - COLLECT waits indefinitely; only cancel, four digits or reset leave it.

## Test plan
- Reset, `start` with `card_acc_num`=5 (found), keys 1,2,3,4 → `pin`=16'h1234 in VERIFY; auth=1, `acc_index_in`=5 → `granted`=1, `acc_index`=5, `done` one cycle, 2 cycles after 4th key.
- `start` with `acc_found_stat`=0 → `done` at N+2, `fail_code`=1, `busy` back to 0, `granted`=0.
- Three wrong 4-digit PINs (auth=0) with `MAX_TRIES`=3 → `tries_left` 3→2→1→0, `locked`=1, `fail_code`=2; later `start` ignored until `rst_n`=0.
- Keys 7, 12, 8, clear, 9,9,9,9 → digit 12 ignored, clear drops "78", `pin`=16'h9999 at VERIFY; `key_cancel` with `key_valid` in another session → `fail_code`=3, no digit stored.
- With `ENTRY_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10: one key, then 10 idle cycles → `done`, `fail_code`=3. Without the macro: 1000 idle cycles, `busy` stays 1.
- `rst_n`=0 for one edge during COLLECT after 2 digits → all outputs at reset values next cycle, no `done`.
